// File: rtl/motor_ramp_ctrl_if.sv
// motor_ramp_ctrl_if: direction/duty command handshake into the ramp controller
interface motor_ramp_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_duty;
  modport master(output cmd_valid, cmd_dir, cmd_duty, input cmd_ready);
  modport slave(input cmd_valid, cmd_dir, cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: rate-limited duty ramp with brake and dead-time direction reversal
module motor_ramp_ctrl #(
  parameter int RAMP_DIV   = 1000,
  parameter int STEP       = 1,
  parameter int DEAD_TICKS = 50000
) (
  input  logic             cin,
  input  logic             rst,
  motor_ramp_ctrl_if.slave cmd,
  input  logic             estop,
  output logic             dir,
  output logic             enable,
  output logic [7:0]       duty_cycle,
  output logic             at_target
);
  localparam int PW = $clog2(RAMP_DIV + 1);
  localparam int DW = $clog2(DEAD_TICKS + 1);
  typedef enum logic [1:0] {IDLE, RUN, BRAKE, DEAD} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [7:0] duty_n, tgt_duty, tgt_duty_n, ramp, brake;
  logic [8:0] up, dn;
  logic tgt_dir, tgt_dir_n, dir_n, live, tick, acc;
  assign tick = pre == PW'(RAMP_DIV - 1);
  assign cmd.cmd_ready = live & ~estop;
  assign acc = cmd.cmd_valid & cmd.cmd_ready;
  assign up = {1'b0, duty_cycle} + 9'(STEP);
  assign dn = {1'b0, duty_cycle} - 9'(STEP);
  assign ramp = duty_cycle < tgt_duty ? (up > {1'b0, tgt_duty} ? tgt_duty : up[7:0])
                                      : (dn[8] || dn[7:0] < tgt_duty ? tgt_duty : dn[7:0]);
  assign brake = dn[8] ? 8'd0 : dn[7:0];
  assign enable = (state == RUN || state == BRAKE) && duty_cycle != 8'd0;
  assign at_target = (state == IDLE || state == RUN) && duty_cycle == tgt_duty && dir == tgt_dir;
  // next state: estop overrides everything; dead counter restarts whenever DEAD is not counting
  always_comb begin
    state_n = state;
    duty_n = duty_cycle;
    dcnt_n = '0;
    dir_n = dir;
    tgt_dir_n = acc ? cmd.cmd_dir : tgt_dir;
    tgt_duty_n = acc ? cmd.cmd_duty : tgt_duty;
    if (estop) begin
      state_n = DEAD;
      duty_n = '0;
      tgt_duty_n = '0;
    end else begin
      case (state)
        IDLE: begin
          duty_n = '0;
          if (tgt_duty != 8'd0) state_n = tgt_dir == dir ? RUN : DEAD;
        end
        RUN: begin
          if (tgt_dir != dir) state_n = duty_cycle != 8'd0 ? BRAKE : DEAD;
          else if (duty_cycle == 8'd0 && tgt_duty == 8'd0) state_n = IDLE;
          else if (tick) duty_n = ramp;
        end
        BRAKE: begin
          if (tgt_dir == dir) state_n = RUN;
          else if (duty_cycle == 8'd0) state_n = DEAD;
          else if (tick) duty_n = brake;
        end
        DEAD: begin
          duty_n = '0;
          if (dcnt == DW'(DEAD_TICKS - 1)) begin
            dir_n = tgt_dir;
            state_n = tgt_duty != 8'd0 ? RUN : IDLE;
          end else dcnt_n = dcnt + DW'(1);
        end
      endcase
    end
  end
  // state, targets and free-running ramp prescaler
  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pre <= '0;
      dcnt <= '0;
      duty_cycle <= '0;
      dir <= 1'b1;
      tgt_dir <= 1'b1;
      tgt_duty <= '0;
      live <= 1'b0;
    end else begin
      state <= state_n;
      pre <= tick ? '0 : pre + PW'(1);
      dcnt <= dcnt_n;
      duty_cycle <= duty_n;
      dir <= dir_n;
      tgt_dir <= tgt_dir_n;
      tgt_duty <= tgt_duty_n;
      live <= 1'b1;
    end
  end
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: directed sequences, settled-output table and randomized commands against a rule-based monitor
module tb_motor_ramp_ctrl;
  localparam int RD = 4;
  localparam int ST = 16;
  localparam int DT = 8;
  logic clk = 0, rst = 1, estop = 0;
  logic dir, enable, at_target;
  logic [7:0] duty_cycle;
  motor_ramp_ctrl_if cmd();
  motor_ramp_ctrl #(.RAMP_DIV(RD), .STEP(ST), .DEAD_TICKS(DT)) dut (
    .cin(clk), .rst(rst), .cmd(cmd), .estop(estop),
    .dir(dir), .enable(enable), .duty_cycle(duty_cycle), .at_target(at_target)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  task automatic chk(input string n, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, got, exp, $time);
    end
  endtask
  // rule monitor: target tracking, tick-aligned bounded steps, dead-time before any direction flip
  int k, zrun, d;
  logic rdy_m, m_dir, p_dir, e_est, e_acc, e_cd;
  logic [7:0] m_duty, p_duty, e_cduty, goal;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      k = 0; zrun = 0; rdy_m = 0; m_dir = 1; m_duty = 0; p_duty = 0; p_dir = 1;
    end else begin
      e_est = estop;
      e_acc = cmd.cmd_valid && rdy_m && !estop;
      e_cd = cmd.cmd_dir;
      e_cduty = cmd.cmd_duty;
      k++;
      #2;
      goal = (p_dir == m_dir) ? m_duty : 8'd0;
      if (e_est) chk("estop_zero", int'(duty_cycle), 0);
      else if (duty_cycle != p_duty) begin
        chk("step_on_tick", k % RD, 0);
        d = int'(duty_cycle) - int'(p_duty);
        chk("step_toward_goal", int'((d > 0 && duty_cycle <= goal) || (d < 0 && duty_cycle >= goal)), 1);
        chk("step_size", int'(d == ST || d == -ST || duty_cycle == goal), 1);
      end
      if (dir != p_dir) begin
        chk("dir_flip_while_off", int'(p_duty == 0 && duty_cycle == 0 && zrun >= DT), 1);
        chk("dir_flip_target", int'(dir), int'(m_dir));
      end
      zrun = (duty_cycle == 0) ? zrun + 1 : 0;
      chk("enable_vs_duty", int'(enable), int'(duty_cycle != 0));
      rdy_m = 1;
      chk("cmd_ready", int'(cmd.cmd_ready), int'(!estop));
      if (e_acc) begin m_dir = e_cd; m_duty = e_cduty; end
      if (e_est) m_duty = 0;
      if (at_target) chk("at_target_implies", int'(duty_cycle == m_duty && dir == m_dir), 1);
      p_duty = duty_cycle;
      p_dir = dir;
    end
  end
  task automatic send(input logic dv, input logic [7:0] v);
    @(negedge clk);
    cmd.cmd_valid = 1; cmd.cmd_dir = dv; cmd.cmd_duty = v;
    @(negedge clk);
    cmd.cmd_valid = 0;
  endtask
  logic [7:0] seq[$];
  int gap[$];
  task automatic collect(input logic [7:0] sd, input logic sdir, input int maxc);
    logic [7:0] last;
    int c, lc;
    last = duty_cycle; c = 0; lc = 0;
    seq.delete(); gap.delete();
    while (!(duty_cycle == sd && dir == sdir) && c < maxc) begin
      @(negedge clk);
      c++;
      if (duty_cycle != last) begin
        seq.push_back(duty_cycle); gap.push_back(c - lc); lc = c; last = duty_cycle;
      end
    end
    chk("reach_target", int'(duty_cycle == sd && dir == sdir), 1);
  endtask
  typedef int iq_t[$];
  task automatic cmp_seq(input string n, input iq_t exp);
    chk({n, "_len"}, seq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seq.size(); i++) chk(n, int'(seq[i]), exp[i]);
  endtask
  task automatic settle_check();
    repeat (300) @(negedge clk);
    chk("settle_duty", int'(duty_cycle), int'(m_duty));
    chk("settle_enable", int'(enable), int'(m_duty != 0));
    if (m_duty != 0) begin
      chk("settle_dir", int'(dir), int'(m_dir));
      chk("settle_at_target", int'(at_target), 1);
    end
  endtask
  typedef struct {
    logic d; logic [7:0] v; logic [7:0] e_duty; logic e_dir; logic e_en; logic e_at;
  } vec_t;
  vec_t tbl[8];
  int c, r;
  logic rd;
  logic [7:0] rv;
  initial begin
    cmd.cmd_valid = 0; cmd.cmd_dir = 1; cmd.cmd_duty = 0;
    tbl[0] = '{1'b1, 8'd64, 8'd64, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 8'd40, 8'd40, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'd255, 8'd255, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'd17, 8'd17, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(duty_cycle), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_ready", int'(cmd.cmd_ready), 0);
    chk("rst_at_target", int'(at_target), 1);
    rst = 0;
    #1 chk("ready_before_edge", int'(cmd.cmd_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", int'(cmd.cmd_ready), 1);
    send(1, 64);
    collect(64, 1, 200);
    cmp_seq("t1_seq", '{16, 32, 48, 64});
    for (int i = 1; i < gap.size(); i++) chk("t1_gap", gap[i], RD);
    chk("t1_at_target", int'(at_target), 1);
    send(0, 40);
    collect(40, 0, 300);
    cmp_seq("t2_seq", '{48, 32, 16, 0, 16, 32, 40});
    send(1, 100);
    collect(100, 1, 300);
    cmp_seq("t3_seq", '{24, 8, 0, 16, 32, 48, 64, 80, 96, 100});
    send(1, 0);
    collect(0, 1, 300);
    cmp_seq("t3_down", '{84, 68, 52, 36, 20, 4, 0});
    repeat (2) @(negedge clk);
    chk("t3_idle_enable", int'(enable), 0);
    chk("t3_idle_at_target", int'(at_target), 1);
    send(1, 200);
    collect(200, 1, 400);
    @(negedge clk);
    estop = 1; cmd.cmd_valid = 1; cmd.cmd_dir = 0; cmd.cmd_duty = 50;
    #1 chk("t4_ready_in_estop", int'(cmd.cmd_ready), 0);
    @(negedge clk);
    chk("t4_duty", int'(duty_cycle), 0);
    chk("t4_enable", int'(enable), 0);
    estop = 0; cmd.cmd_valid = 0;
    #1 chk("t4_in_dead", int'(at_target), 0);
    c = 0;
    while (!at_target && c < 50) begin @(negedge clk); c++; end
    chk("t4_dead_len", c, DT);
    chk("t4_dir", int'(dir), 1);
    chk("t4_idle_duty", int'(duty_cycle), 0);
    send(1, 64);
    collect(64, 1, 200);
    send(0, 40);
    collect(32, 1, 100);
    send(1, 80);
    collect(80, 1, 200);
    cmp_seq("t6_seq", '{48, 64, 80});
    send(0, 40);
    collect(32, 1, 100);
    @(negedge clk);
    chk("t5_pre_duty", int'(duty_cycle), 32);
    chk("t5_pre_enable", int'(enable), 1);
    #1 rst = 1;
    #1;
    chk("t5_duty", int'(duty_cycle), 0);
    chk("t5_enable", int'(enable), 0);
    chk("t5_dir", int'(dir), 1);
    chk("t5_ready", int'(cmd.cmd_ready), 0);
    chk("t5_at_target", int'(at_target), 1);
    repeat (2) @(negedge clk);
    rst = 0;
    #1 chk("t5_ready_before_edge", int'(cmd.cmd_ready), 0);
    @(posedge clk);
    #1 chk("t5_ready_after_edge", int'(cmd.cmd_ready), 1);
    foreach (tbl[i]) begin
      send(tbl[i].d, tbl[i].v);
      repeat (300) @(negedge clk);
      chk($sformatf("tbl%0d_duty", i), int'(duty_cycle), int'(tbl[i].e_duty));
      chk($sformatf("tbl%0d_dir", i), int'(dir), int'(tbl[i].e_dir));
      chk($sformatf("tbl%0d_enable", i), int'(enable), int'(tbl[i].e_en));
      chk($sformatf("tbl%0d_at_target", i), int'(at_target), int'(tbl[i].e_at));
    end
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        @(negedge clk);
        estop = 1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        estop = 0;
      end else begin
        rd = 1'($urandom_range(0, 1));
        rv = r == 1 ? 8'd0 : r == 2 ? 8'd255 : 8'($urandom_range(0, 255));
        send(rd, rv);
      end
      repeat ($urandom_range(1, 120)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) settle_check();
    end
    settle_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
